// File: rtl/fft_i_switch_if.sv
// Butterfly-result input bundle and paired bank write outputs of the FFT write-back switch.
interface fft_i_switch_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 18
);
    logic                  first_level;
    logic                  butterfly_vld;
    logic [ADDR_WIDTH-1:0] addr_index;
    logic [DATA_WIDTH-1:0] butterfly_aout;
    logic [DATA_WIDTH-1:0] butterfly_bout;
    logic                  o_wr_valid;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [DATA_WIDTH-1:0] oa_wr_data;
    logic [DATA_WIDTH-1:0] ob_wr_data;
    logic                  o_orphan;

    modport slave (
        input  first_level, butterfly_vld, addr_index, butterfly_aout, butterfly_bout,
        output o_wr_valid, o_wr_addr, oa_wr_data, ob_wr_data, o_orphan
    );

    modport master (
        output first_level, butterfly_vld, addr_index, butterfly_aout, butterfly_bout,
        input  o_wr_valid, o_wr_addr, oa_wr_data, ob_wr_data, o_orphan
    );
endinterface

// File: rtl/fft_i_switch.sv
// FFT write-back switch: level-0 pass-through, 2x2 transpose of beat pairs on later levels.
// Fixed two-cycle latency: one input register stage, one output register stage.
module fft_i_switch #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_i_switch_if.slave   bus
);
    typedef enum logic {HEAD = 1'b0, TAIL = 1'b1} phase_t;

    phase_t                phase, phase_nxt;
    logic                  mode_fl;
    logic                  beat_fl;

    logic                  s1_vld;
    logic                  s1_fl;
    logic                  s1_tail;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_a;
    logic [DATA_WIDTH-1:0] s1_b;
    logic [DATA_WIDTH-1:0] pend_b;

    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] a_d;
    logic [DATA_WIDTH-1:0] b_d;
    logic                  orphan_d;

    // s1_vld doubles as "previous cycle had a beat", which defines burst start.
    assign beat_fl = (bus.butterfly_vld && !s1_vld) ? bus.first_level : mode_fl;

    always_comb begin
        phase_nxt = HEAD;
        if (bus.butterfly_vld)
            phase_nxt = (phase == HEAD) ? TAIL : HEAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= HEAD;
            mode_fl <= 1'b0;
            s1_vld  <= 1'b0;
            s1_fl   <= 1'b0;
            s1_tail <= 1'b0;
            s1_addr <= '0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else begin
            phase  <= phase_nxt;
            s1_vld <= bus.butterfly_vld;
            if (bus.butterfly_vld) begin
                mode_fl <= beat_fl;
                s1_fl   <= beat_fl;
                s1_tail <= (phase == TAIL);
                s1_addr <= bus.addr_index;
                s1_a    <= bus.butterfly_aout;
                s1_b    <= bus.butterfly_bout;
            end
        end
    end

    // A staged head looks at the live input: a beat there is its tail, otherwise it is an orphan.
    always_comb begin
        addr_d   = s1_addr;
        a_d      = s1_a;
        b_d      = s1_b;
        orphan_d = 1'b0;
        if (!s1_fl) begin
            if (!s1_tail) begin
                if (bus.butterfly_vld)
                    b_d = bus.butterfly_aout;
                else
                    orphan_d = 1'b1;
            end else begin
                a_d = pend_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_b         <= '0;
            bus.o_wr_valid <= 1'b0;
            bus.o_wr_addr  <= '0;
            bus.oa_wr_data <= '0;
            bus.ob_wr_data <= '0;
            bus.o_orphan   <= 1'b0;
        end else begin
            bus.o_wr_valid <= s1_vld;
            bus.o_orphan   <= s1_vld & orphan_d;
            if (s1_vld && !s1_tail)
                pend_b <= s1_b;
            if (s1_vld) begin
                bus.o_wr_addr  <= addr_d;
                bus.oa_wr_data <= a_d;
                bus.ob_wr_data <= b_d;
            end
        end
    end
endmodule

// File: tb/tb_fft_i_switch.sv
// Scoreboard bench for fft_i_switch: a burst-level model queues expected writes, a monitor pops and compares.
module tb_fft_i_switch;
    localparam int AW = 18;
    localparam int DW = 18;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          orphan;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_i_switch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fft_i_switch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned passed = 0;
    wr_t exp_q[$];

    // Burst-level reference state
    logic          m_prev_vld = 1'b0;
    logic          m_mode     = 1'b0;
    logic          m_have_head = 1'b0;
    wr_t           m_head;

    // Monitor state
    logic          mon_cur = 1'b0;
    logic          mon_prev = 1'b0;
    wr_t           last_wr = '{addr: '0, a: '0, b: '0, orphan: 1'b0};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    endtask

    function automatic wr_t mk(input logic [AW-1:0] addr, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic orphan);
        wr_t w;
        w.addr = addr; w.a = a; w.b = b; w.orphan = orphan;
        return w;
    endfunction

    // Drive one cycle and record what the write-side must produce for it.
    task automatic drive(input logic v, input logic fl, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [AW-1:0] i);
        @(negedge clk);
        bus.butterfly_vld  = v;
        bus.first_level    = fl;
        bus.butterfly_aout = a;
        bus.butterfly_bout = b;
        bus.addr_index     = i;
        if (v) begin
            if (!m_prev_vld) m_mode = fl;
            if (m_mode) begin
                exp_q.push_back(mk(i, a, b, 1'b0));
            end else if (!m_have_head) begin
                m_head = mk(i, a, b, 1'b0);
                m_have_head = 1'b1;
            end else begin
                exp_q.push_back(mk(m_head.addr, m_head.a, a, 1'b0));
                exp_q.push_back(mk(i, m_head.b, b, 1'b0));
                m_have_head = 1'b0;
            end
        end else if (m_have_head) begin
            exp_q.push_back(mk(m_head.addr, m_head.a, m_head.b, 1'b1));
            m_have_head = 1'b0;
        end
        m_prev_vld = v;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.butterfly_vld = 1'b0;
        #1;
        check("rst_valid",  {63'd0, bus.o_wr_valid}, 64'd0);
        check("rst_addr",   {46'd0, bus.o_wr_addr},  64'd0);
        check("rst_a",      {46'd0, bus.oa_wr_data}, 64'd0);
        check("rst_b",      {46'd0, bus.ob_wr_data}, 64'd0);
        check("rst_orphan", {63'd0, bus.o_orphan},   64'd0);
        exp_q.delete();
        m_prev_vld  = 1'b0;
        m_have_head = 1'b0;
        last_wr     = mk('0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        mon_prev = mon_cur;
        mon_cur  = bus.butterfly_vld;
        #1;
        if (!rst_n) begin
            mon_prev = 1'b0;
            mon_cur  = 1'b0;
        end else begin
            check("valid_lat2", {63'd0, bus.o_wr_valid}, {63'd0, mon_prev});
            if (bus.o_wr_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", {46'd0, bus.o_wr_addr},  {46'd0, e.addr});
                    check("wr_a",    {46'd0, bus.oa_wr_data}, {46'd0, e.a});
                    check("wr_b",    {46'd0, bus.ob_wr_data}, {46'd0, e.b});
                    check("orphan",  {63'd0, bus.o_orphan},   {63'd0, e.orphan});
                    last_wr = e;
                end
            end else begin
                check("hold_addr",   {46'd0, bus.o_wr_addr},  {46'd0, last_wr.addr});
                check("hold_a",      {46'd0, bus.oa_wr_data}, {46'd0, last_wr.a});
                check("hold_b",      {46'd0, bus.ob_wr_data}, {46'd0, last_wr.b});
                check("idle_orphan", {63'd0, bus.o_orphan},   64'd0);
            end
        end
    end

    initial begin
        bus.butterfly_vld  = 1'b0;
        bus.first_level    = 1'b0;
        bus.butterfly_aout = '0;
        bus.butterfly_bout = '0;
        bus.addr_index     = '0;
        do_reset();
        idle(2);

        // Level-0 pass-through
        drive(1'b1, 1'b1, 18'd1, 18'd2, 18'h10);
        drive(1'b1, 1'b1, 18'd3, 18'd4, 18'h11);
        drive(1'b1, 1'b1, 18'd5, 18'd6, 18'h12);
        idle(3);

        // Transposed even burst
        drive(1'b1, 1'b0, 18'd1, 18'd2, 18'd0);
        drive(1'b1, 1'b0, 18'd3, 18'd4, 18'd1);
        drive(1'b1, 1'b0, 18'd5, 18'd6, 18'd2);
        drive(1'b1, 1'b0, 18'd7, 18'd8, 18'd3);
        idle(3);

        // Odd burst ends with an orphan
        drive(1'b1, 1'b0, 18'd1, 18'd2, 18'd0);
        drive(1'b1, 1'b0, 18'd3, 18'd4, 18'd1);
        drive(1'b1, 1'b0, 18'd5, 18'd6, 18'd2);
        idle(3);

        // Mode toggled mid-burst, then a level-0 burst after one idle cycle
        drive(1'b1, 1'b0, 18'h21, 18'h22, 18'h30);
        drive(1'b1, 1'b1, 18'h23, 18'h24, 18'h31);
        drive(1'b0, 1'b1, 18'h0,  18'h0,  18'h0);
        drive(1'b1, 1'b1, 18'h25, 18'h26, 18'h32);
        drive(1'b1, 1'b0, 18'h27, 18'h28, 18'h33);
        idle(3);

        // Single-cycle gap between head and would-be tail
        drive(1'b1, 1'b0, 18'h41, 18'h42, 18'h50);
        drive(1'b0, 1'b0, 18'h0,  18'h0,  18'h0);
        drive(1'b1, 1'b0, 18'h43, 18'h44, 18'h51);
        drive(1'b1, 1'b0, 18'h45, 18'h46, 18'h52);
        idle(3);

        // Reset right after a non-first head
        drive(1'b1, 1'b0, 18'h61, 18'h62, 18'h70);
        do_reset();
        idle(1);
        drive(1'b1, 1'b0, 18'h63, 18'h64, 18'h71);
        drive(1'b1, 1'b0, 18'h65, 18'h66, 18'h72);
        idle(3);

        // Random mode/gap stress with occasional reset
        for (int unsigned c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
                      DW'($urandom), DW'($urandom), AW'($urandom));
            end
        end
        idle(4);
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
